exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16: operand, result and write-back width; SHALL match the register file width.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-005 op_code  input  3  operation select, encoding per REQ-012.
REQ-006 op1  input  DATA_WIDTH  first operand, from the register file rs1 read port.
REQ-007 op2  input  DATA_WIDTH  second operand, from the register file rs2 read port.
REQ-008 rd_in  input  2  destination register index.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 wb_en, wb_rd[1:0], wb_data[DATA_WIDTH-1:0], flag_zero, flag_carry  outputs  register-file write-back and status.

Function
REQ-012 Opcodes SHALL be: 000 ADD, 001 SUB (op1-op2), 010 AND, 011 OR, 100 XOR, 101 SHL (op1 << op2[3:0]), 110 MUL (low DATA_WIDTH bits of op1*op2), 111 MOV (result = op2).
REQ-013 FSM states SHALL be IDLE, MUL, WB.
REQ-014 IDLE with start=1 SHALL latch op_code, op1, op2 and rd_in on that edge.
- Inputs SHALL be ignored in every other state.
REQ-015 IDLE + start + non-MUL opcode SHALL compute the result on the same edge and go to WB.
- Latency: done high in the cycle immediately after the start edge.
REQ-016 IDLE + start + MUL SHALL go to MUL and clear the accumulator and a 4-bit-wide-or-larger iteration counter.
REQ-017 MUL state SHALL perform one shift-add step per cycle (LSB-first on the multiplier) for exactly DATA_WIDTH cycles, then go to WB.
- For DATA_WIDTH=16, done is high 17 cycles after the start edge.
REQ-018 WB SHALL last exactly one cycle, with done=1 and wb_en=1, then return to IDLE.
REQ-019 A start pulse in WB SHALL be ignored; back-to-back operations SHALL have at least one IDLE cycle between them.
REQ-020 wb_rd SHALL equal the latched rd_in and wb_data SHALL equal the result, both registered.
- Both SHALL be held stable until the next WB.
REQ-021 done and wb_en SHALL be 0 in every state other than WB.
REQ-022 flag_zero SHALL be 1 when the DATA_WIDTH-bit result equals 0.
REQ-023 flag_carry SHALL be:
- ADD: carry-out.
- SUB: borrow (op1 < op2, unsigned).
- SHL: OR of the bits shifted out.
- MUL: OR of product bits above DATA_WIDTH-1.
- Otherwise: 0.
REQ-024 Both flags SHALL update only at WB entry and hold their value until the next WB.
REQ-025 All arithmetic SHALL be unsigned modulo 2^DATA_WIDTH.
- SHL by 0 SHALL return op1 unchanged with carry 0.
REQ-026 An undefined or X opcode SHALL NOT occur; all 8 encodings are defined.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and set all outputs to 0: busy, done, wb_en, wb_rd, wb_data, flag_zero, flag_carry.
REQ-028 The accumulator, counter and latched operands SHALL also clear to 0 on reset.
REQ-029 Reset asserted during MUL or WB SHALL abort the operation with no write-back pulse.
- After release, the block SHALL be in IDLE and accept start on the first rising edge.

Verification
REQ-030 ADD 0xFFFF+0x0001, rd_in=2 -> next cycle: done=1, wb_en=1, wb_rd=2, wb_data=0x0000, zero=1, carry=1.
REQ-031 SUB 0x0003-0x0005 -> wb_data=0xFFFE, carry=1, zero=0; SHL 0x0003 by 15 -> wb_data=0x8000, carry=1.
REQ-032 MUL 0x0012*0x0034, rd_in=3 -> busy for 17 cycles, done at cycle 17, wb_data=0x03A8, carry=0, wb_rd=3.
REQ-033 MUL 0x0100*0x0100 -> wb_data=0x0000, zero=1, carry=1.
- Changing op1/op2 and pulsing start during MUL SHALL have no effect on the result or the timing.
REQ-034 rst_n pulsed low at cycle 5 of a MUL -> no done/wb_en pulse, all outputs 0.
- A following ADD 0x0001+0x0001 SHALL give wb_data=0x0002 with done one cycle after its start.

Source files
------------

// File: rtl/exec_unit.sv
// Multi-cycle execution unit: single-cycle ALU ops and a 16-step shift-add multiplier,
// with a registered register-file write-back port and zero/carry status.
module exec_unit #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op_code,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [1:0]            rd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  wb_en,
  output logic [1:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  flag_zero,
  output logic                  flag_carry
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_e;

  // Single-cycle ALU result; bit DATA_WIDTH carries the carry/borrow/shift-out flag.
  function automatic logic [DATA_WIDTH:0] alu_f(
    input logic [2:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0]     wide;
    logic [2*DATA_WIDTH-1:0] shl;
    wide = {(DATA_WIDTH+1){1'b0}};
    shl  = {{DATA_WIDTH{1'b0}}, a} << b[3:0];
    case (op)
      OP_ADD: wide = {1'b0, a} + {1'b0, b};
      OP_SUB: wide = {1'b0, a} - {1'b0, b};
      OP_AND: wide = {1'b0, a & b};
      OP_OR:  wide = {1'b0, a | b};
      OP_XOR: wide = {1'b0, a ^ b};
      OP_SHL: wide = {|shl[2*DATA_WIDTH-1:DATA_WIDTH], shl[DATA_WIDTH-1:0]};
      OP_MOV: wide = {1'b0, b};
      default: wide = {(DATA_WIDTH+1){1'b0}};
    endcase
    return wide;
  endfunction

  state_e                  state_r, state_nxt_s;
  logic [2:0]              op_r;
  logic [1:0]              rd_r;
  logic [2*DATA_WIDTH-1:0] mcand_r;
  logic [DATA_WIDTH-1:0]   mplier_r;
  logic [2*DATA_WIDTH-1:0] acc_r, acc_nxt_s;
  logic [CW-1:0]           cnt_r;
  logic                    mul_last_s;
  logic [DATA_WIDTH:0]     alu_s;
  logic                    busy_r, done_r, wb_en_r, flag_zero_r, flag_carry_r;
  logic [1:0]              wb_rd_r;
  logic [DATA_WIDTH-1:0]   wb_data_r;

  // Next-state decode plus the combinational ALU and the next multiplier partial sum.
  always_comb begin
    state_nxt_s = state_r;
    alu_s       = alu_f(op_code, op1, op2);
    acc_nxt_s   = acc_r + (mplier_r[0] ? mcand_r : {(2*DATA_WIDTH){1'b0}});
    mul_last_s  = (cnt_r == CW'(DATA_WIDTH - 1));
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = (op_code == OP_MUL) ? MUL : WB;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (mul_last_s) begin
          state_nxt_s = WB;
        end else begin
          state_nxt_s = MUL;
        end
      end
      WB:      state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch, shift-add datapath and registered write-back/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r         <= 3'b000;
      rd_r         <= 2'b00;
      mcand_r      <= {(2*DATA_WIDTH){1'b0}};
      mplier_r     <= {DATA_WIDTH{1'b0}};
      acc_r        <= {(2*DATA_WIDTH){1'b0}};
      cnt_r        <= {CW{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      wb_en_r      <= 1'b0;
      wb_rd_r      <= 2'b00;
      wb_data_r    <= {DATA_WIDTH{1'b0}};
      flag_zero_r  <= 1'b0;
      flag_carry_r <= 1'b0;
    end else begin
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == WB);
      wb_en_r <= (state_nxt_s == WB);
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r     <= op_code;
            rd_r     <= rd_in;
            mcand_r  <= {{DATA_WIDTH{1'b0}}, op1};
            mplier_r <= op2;
            acc_r    <= {(2*DATA_WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            if (op_code != OP_MUL) begin
              wb_rd_r      <= rd_in;
              wb_data_r    <= alu_s[DATA_WIDTH-1:0];
              flag_zero_r  <= (alu_s[DATA_WIDTH-1:0] == {DATA_WIDTH{1'b0}});
              flag_carry_r <= alu_s[DATA_WIDTH];
            end
          end
        end
        MUL: begin
          acc_r    <= acc_nxt_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (mul_last_s) begin
            wb_rd_r      <= rd_r;
            wb_data_r    <= acc_nxt_s[DATA_WIDTH-1:0];
            flag_zero_r  <= (acc_nxt_s[DATA_WIDTH-1:0] == {DATA_WIDTH{1'b0}});
            flag_carry_r <= (op_r == OP_MUL) && (|acc_nxt_s[2*DATA_WIDTH-1:DATA_WIDTH]);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign wb_en      = wb_en_r;
  assign wb_rd      = wb_rd_r;
  assign wb_data    = wb_data_r;
  assign flag_zero  = flag_zero_r;
  assign flag_carry = flag_carry_r;

endmodule

// File: tb/tb_exec_unit.sv
// Randomized self-checking bench for exec_unit against an arithmetic reference model.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op_code = 3'b000;
  logic [15:0] op1 = 16'h0000;
  logic [15:0] op2 = 16'h0000;
  logic [1:0]  rd_in = 2'b00;
  logic        busy, done, wb_en, flag_zero, flag_carry;
  logic [1:0]  wb_rd;
  logic [15:0] wb_data;

  int errors = 0;
  int checks = 0;

  exec_unit #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code),
    .op1(op1), .op2(op2), .rd_in(rd_in), .busy(busy), .done(done),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_zero(flag_zero), .flag_carry(flag_carry)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, result} straight from the opcode definitions.
  function automatic logic [16:0] ref_op(input int op, input int a, input int b);
    longint la, lb, r;
    logic   c;
    la = longint'(a);
    lb = longint'(b);
    case (op)
      0: begin r = la + lb;          c = (r >> 16) != 0; end
      1: begin r = la - lb;          c = (la < lb);      end
      2: begin r = la & lb;          c = 1'b0;           end
      3: begin r = la | lb;          c = 1'b0;           end
      4: begin r = la ^ lb;          c = 1'b0;           end
      5: begin r = la << (lb % 16);  c = (r >> 16) != 0; end
      6: begin r = la * lb;          c = (r >> 16) != 0; end
      default: begin r = lb;         c = 1'b0;           end
    endcase
    return {c, r[15:0]};
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] rd, input bit perturb, input bit wait_edge);
    logic [16:0] exp_v;
    int          exp_lat;
    int          lat;
    bit          seen;
    exp_v   = ref_op(int'(op), int'(a), int'(b));
    exp_lat = (op == 3'd6) ? 17 : 1;
    if (wait_edge) @(negedge clk);
    op_code = op; op1 = a; op2 = b; rd_in = rd; start = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (perturb) begin
        start   = 1'($urandom_range(0, 1));
        op_code = 3'($urandom);
        op1     = 16'($urandom);
        op2     = 16'($urandom);
        rd_in   = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      check_eq("busy", 32'(busy), 32'd1);
      if (done) seen = 1'b1;
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("wb_en", 32'(wb_en), 32'd1);
    check_eq("wb_rd", 32'(wb_rd), 32'(rd));
    check_eq("wb_data", 32'(wb_data), 32'(exp_v[15:0]));
    check_eq("zero", 32'(flag_zero), 32'(exp_v[15:0] == 16'h0000));
    check_eq("carry", 32'(flag_carry), 32'(exp_v[16]));
    @(negedge clk);
    start = 1'b0;
    check_eq("done_drop", 32'(done), 32'd0);
    check_eq("wb_en_drop", 32'(wb_en), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("data_hold", 32'(wb_data), 32'(exp_v[15:0]));
    check_eq("carry_hold", 32'(flag_carry), 32'(exp_v[16]));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_wb_en"}, 32'(wb_en), 32'd0);
    check_eq({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    check_eq({tag, "_wb_data"}, 32'(wb_data), 32'd0);
    check_eq({tag, "_zero"}, 32'(flag_zero), 32'd0);
    check_eq({tag, "_carry"}, 32'(flag_carry), 32'd0);
  endtask

  initial begin
    #12;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed boundary cases
    do_op(3'd0, 16'hFFFF, 16'h0001, 2'd2, 1'b0, 1'b1);
    do_op(3'd1, 16'h0003, 16'h0005, 2'd1, 1'b0, 1'b1);
    do_op(3'd5, 16'h0003, 16'h000F, 2'd0, 1'b0, 1'b1);
    do_op(3'd5, 16'hA5A5, 16'h0010, 2'd3, 1'b0, 1'b1);
    do_op(3'd6, 16'h0012, 16'h0034, 2'd3, 1'b0, 1'b1);
    do_op(3'd6, 16'h0100, 16'h0100, 2'd1, 1'b1, 1'b1);
    do_op(3'd6, 16'hFFFF, 16'hFFFF, 2'd2, 1'b1, 1'b1);
    do_op(3'd7, 16'h1234, 16'h0000, 2'd0, 1'b1, 1'b1);

    // Randomized operations, some with input churn while busy
    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset in the middle of a multiply aborts it
    @(negedge clk);
    op_code = 3'd6; op1 = 16'h00FF; op2 = 16'h00FF; rd_in = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    check_eq("mul_busy_pre_rst", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    do_op(3'd0, 16'h0001, 16'h0001, 2'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
